board_id_negotiator: RTL and testbench

Claims a unique board ID for this board in a multi-board game setup by negotiating over shared per-slot claim lines with up to MAX_BOARDS peers. Generalises the fixed two-slot ID assignment: parametrised slot count, synchronised external claim inputs, collision detection during a settle window, and pseudo-random backoff. Sits between the board-link I/O pins and game logic, which consumes `board_ID` and `id_valid`.

---
 rtl/board_id_if.sv | 25 ++
 rtl/board_id_negotiator.sv | 105 ++++++++++
 tb/tb_board_id_negotiator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/board_id_if.sv
// board_id_if: board-link handshake between game logic/pins and the ID negotiator
// master: drives lock_ID_en, release_ID, ext_claim; observes claim/ID status
// slave:  the negotiator; drives claim_out, occupied, board_ID, id_valid, no_id, busy
interface board_id_if #(
  parameter int MAX_BOARDS = 4,
  parameter int ID_W       = 8
);
  logic                  lock_ID_en;
  logic                  release_ID;
  logic [MAX_BOARDS-1:0] ext_claim;
  logic [MAX_BOARDS-1:0] claim_out;
  logic [MAX_BOARDS-1:0] occupied;
  logic [ID_W-1:0]       board_ID;
  logic                  id_valid;
  logic                  no_id;
  logic                  busy;
  modport master (
    output lock_ID_en, release_ID, ext_claim,
    input  claim_out, occupied, board_ID, id_valid, no_id, busy
  );
  modport slave (
    input  lock_ID_en, release_ID, ext_claim,
    output claim_out, occupied, board_ID, id_valid, no_id, busy
  );
endinterface

// File: rtl/board_id_negotiator.sv
// board_id_negotiator: claims a unique board ID over shared per-slot claim lines with collision backoff
// Ports: clk, rst_n (async active-low); bus (board_id_if.slave):
//   lock_ID_en/release_ID/ext_claim in; claim_out/occupied/board_ID/id_valid/no_id/busy out.
// Optional feature: define BOARD_ID_RELEASE_EN to let release_ID drop a locked ID.
module board_id_negotiator #(
  parameter int         MAX_BOARDS    = 4,
  parameter int         ID_W          = 8,
  parameter int         SETTLE_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  board_id_if.slave   bus
);
  localparam int KW = (MAX_BOARDS > 1) ? $clog2(MAX_BOARDS) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  // status outputs are state bits: [4] busy, [3] no_id, [2] id_valid
  typedef enum logic [4:0] {
    IDLE    = 5'b00000,
    SCAN    = 5'b10000,
    CLAIM   = 5'b10001,
    BACKOFF = 5'b10010,
    FULL    = 5'b01000,
    LOCKED  = 5'b00100
  } state_t;
  state_t                state;
  logic [MAX_BOARDS-1:0] ext_m, ext_s, claim;
  logic [7:0]            lfsr;
  logic [KW-1:0]         k, free_idx;
  logic [CW-1:0]         cnt;
  logic [4:0]            bo;
  logic [ID_W-1:0]       board_id;
  logic                  free;
  assign free = ~&ext_s;
  always_comb begin
    free_idx = '0;
    for (int i = MAX_BOARDS - 1; i >= 0; i--)
      if (!ext_s[i]) free_idx = KW'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_m    <= '0;
      ext_s    <= '0;
      lfsr     <= LFSR_SEED;
      state    <= IDLE;
      k        <= '0;
      cnt      <= '0;
      bo       <= '0;
      claim    <= '0;
      board_id <= '0;
    end else begin
      ext_m <= bus.ext_claim;
      ext_s <= ext_m;
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if ((state[4] || state[3]) && !bus.lock_ID_en) begin
        state <= IDLE;
        claim <= '0;
      end else begin
        case (state)
          IDLE: if (bus.lock_ID_en) state <= SCAN;
          SCAN: begin
            state <= free ? CLAIM : FULL;
            k     <= free_idx;
            claim <= free ? MAX_BOARDS'(1) << free_idx : '0;
            cnt   <= '0;
          end
          CLAIM: begin
            // claim is one-hot, so this tests the peer line of our own slot only
            if (|(ext_s & claim)) begin
              state <= BACKOFF;
              claim <= '0;
              bo    <= 5'd1 + {1'b0, lfsr[3:0]};
            end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
              state    <= LOCKED;
              board_id <= ID_W'(k) + ID_W'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          BACKOFF: begin
            bo <= bo - 5'd1;
            if (bo == 5'd1) state <= SCAN;
          end
          FULL: if (free) state <= SCAN;
          LOCKED: begin
`ifdef BOARD_ID_RELEASE_EN
            if (bus.release_ID) begin
              state    <= IDLE;
              claim    <= '0;
              board_id <= '0;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign bus.claim_out = claim;
  assign bus.occupied  = ext_s | claim;
  assign bus.board_ID  = board_id;
  assign bus.busy      = state[4];
  assign bus.no_id     = state[3];
  assign bus.id_valid  = state[2];
endmodule

// File: tb/tb_board_id_negotiator.sv
// tb_board_id_negotiator: table-driven lock vectors plus hand-written collision/release/reset sequences
module tb_board_id_negotiator;
  localparam int MB = 4;
  localparam int IW = 8;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  board_id_if #(.MAX_BOARDS(MB), .ID_W(IW)) bus ();
  board_id_negotiator #(
    .MAX_BOARDS(MB), .ID_W(IW), .SETTLE_CYCLES(16), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct packed {
    logic [MB-1:0] ext;
    logic [MB-1:0] claim;
    logic [IW-1:0] id;
    logic          full;
  } vec_t;
  vec_t tbl [6];
  vec_t q [$];
  int n_vec  = 0;
  int n_fail = 0;
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    bus.lock_ID_en = 1'b0;
    bus.release_ID = 1'b0;
    bus.ext_claim  = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask
  task automatic wait_done(input int lim);
    int c = 0;
    while (!(bus.id_valid || bus.no_id) && c < lim) begin
      tick(1);
      c++;
    end
    chk("done_within_bound", 32'(bus.id_valid | bus.no_id), 32'd1);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t e;
    int bo, c;
    tbl[0] = '{ext: 4'b0000, claim: 4'b0001, id: 8'd1, full: 1'b0};
    tbl[1] = '{ext: 4'b0011, claim: 4'b0100, id: 8'd3, full: 1'b0};
    tbl[2] = '{ext: 4'b0001, claim: 4'b0010, id: 8'd2, full: 1'b0};
    tbl[3] = '{ext: 4'b0111, claim: 4'b1000, id: 8'd4, full: 1'b0};
    tbl[4] = '{ext: 4'b1010, claim: 4'b0001, id: 8'd1, full: 1'b0};
    tbl[5] = '{ext: 4'b1111, claim: 4'b0000, id: 8'd0, full: 1'b1};
    bus.lock_ID_en = 1'b0;
    bus.release_ID = 1'b0;
    bus.ext_claim  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_claim_out", 32'(bus.claim_out), 32'd0);
    chk("rst_occupied", 32'(bus.occupied), 32'd0);
    chk("rst_board_ID", 32'(bus.board_ID), 32'd0);
    chk("rst_flags", {29'd0, bus.id_valid, bus.no_id, bus.busy}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.ext_claim = tbl[i].ext;
      tick(3);
      bus.lock_ID_en = 1'b1;
      q.push_back(tbl[i]);
      tick(2);
      chk($sformatf("v%0d_claim_at_2", i), 32'(bus.claim_out), 32'(tbl[i].claim));
      tick(15);
      chk($sformatf("v%0d_not_valid_at_17", i), 32'(bus.id_valid), 32'd0);
      wait_done(40);
      e = q.pop_front();
      chk($sformatf("v%0d_claim_out", i), 32'(bus.claim_out), 32'(e.claim));
      chk($sformatf("v%0d_board_ID", i), 32'(bus.board_ID), 32'(e.id));
      chk($sformatf("v%0d_id_valid", i), 32'(bus.id_valid), 32'(!e.full));
      chk($sformatf("v%0d_no_id", i), 32'(bus.no_id), 32'(e.full));
      chk($sformatf("v%0d_occupied", i), 32'(bus.occupied), 32'(e.ext | e.claim));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd0);
    end
    bus.ext_claim = 4'b1011;
    tick(3);
    chk("full_exit_scan_busy", 32'(bus.busy), 32'd1);
    chk("full_exit_claim_0", 32'(bus.claim_out), 32'd0);
    tick(1);
    chk("full_exit_claim", 32'(bus.claim_out), 32'b0100);
    wait_done(40);
    chk("full_exit_id", 32'(bus.board_ID), 32'd3);
    do_reset();
    tick(3);
    bus.lock_ID_en = 1'b1;
    tick(2);
    chk("col_claim_start", 32'(bus.claim_out), 32'b0001);
    tick(5);
    bus.ext_claim = 4'b0001;
    tick(2);
    chk("col_claim_still", 32'(bus.claim_out), 32'b0001);
    chk("col_occupied", 32'(bus.occupied), 32'b0001);
    tick(1);
    chk("col_claim_dropped", 32'(bus.claim_out), 32'd0);
    chk("col_backoff_busy", 32'(bus.busy), 32'd1);
    bo = 1 + int'(m_prev[3:0]);
    c = 0;
    while (bus.claim_out == '0 && c < 40) begin
      tick(1);
      c++;
    end
    chk("col_backoff_len", 32'(c), 32'(bo + 1));
    chk("col_reclaim", 32'(bus.claim_out), 32'b0010);
    wait_done(40);
    chk("col_board_ID", 32'(bus.board_ID), 32'd2);
    chk("col_occupied_locked", 32'(bus.occupied), 32'b0011);
    do_reset();
    bus.lock_ID_en = 1'b1;
    tick(7);
    chk("drop_busy_before", 32'(bus.busy), 32'd1);
    bus.lock_ID_en = 1'b0;
    tick(1);
    chk("drop_claim", 32'(bus.claim_out), 32'd0);
    chk("drop_busy", 32'(bus.busy), 32'd0);
    chk("drop_board_ID", 32'(bus.board_ID), 32'd0);
    do_reset();
    bus.lock_ID_en = 1'b1;
    wait_done(40);
    chk("rel_locked_id", 32'(bus.board_ID), 32'd1);
    bus.release_ID = 1'b1;
    tick(1);
    bus.release_ID = 1'b0;
`ifdef BOARD_ID_RELEASE_EN
    chk("rel_id_cleared", 32'(bus.board_ID), 32'd0);
    chk("rel_valid_cleared", 32'(bus.id_valid), 32'd0);
    chk("rel_claim_cleared", 32'(bus.claim_out), 32'd0);
    tick(1);
    chk("rel_rescan_busy", 32'(bus.busy), 32'd1);
    wait_done(40);
    chk("rel_relock_id", 32'(bus.board_ID), 32'd1);
`else
    tick(2);
    chk("rel_ignored_id", 32'(bus.board_ID), 32'd1);
    chk("rel_ignored_valid", 32'(bus.id_valid), 32'd1);
`endif
    bus.ext_claim  = 4'b0001;
    bus.lock_ID_en = 1'b0;
    tick(5);
    chk("lock_peer_valid", 32'(bus.id_valid), 32'd1);
    chk("lock_peer_claim", 32'(bus.claim_out), 32'b0001);
    chk("lock_peer_id", 32'(bus.board_ID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_claim", 32'(bus.claim_out), 32'd0);
    chk("arst_occupied", 32'(bus.occupied), 32'd0);
    chk("arst_board_ID", 32'(bus.board_ID), 32'd0);
    chk("arst_flags", {29'd0, bus.id_valid, bus.no_id, bus.busy}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
